// File: rtl/ddfs_sweep_ctrl.sv
// ddfs_sweep_ctrl -- frequency sweep sequencer for a DDFS carrier FCW.
//
// Purpose:
//   On a start request the sweep configuration is captured into shadow
//   registers. The sweep then steps the carrier frequency control word from
//   start_fcw to stop_fcw (inclusive) in increments of step. Each FCW value
//   is held for dwell+1 cycles. A configuration with a zero step, or with
//   start above stop, is rejected: the block reports done together with
//   cfg_err and does not touch the FCW.
//
// Build option:
//   DDFS_SWEEP_WRAP_EN -- when defined, cont_i selects a continuous sweep
//   that reloads start_fcw (pulsing wrap_o) instead of finishing. When it is
//   undefined, cont_i is ignored and wrap_o is tied low.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   start_i      one-cycle sweep request (accepted only in IDLE, abort_i low)
//   abort_i      terminates a running sweep, highest priority
//   start_fcw_i  first FCW of the sweep
//   stop_fcw_i   last permitted FCW (inclusive)
//   step_i       FCW increment per step
//   dwell_i      extra hold cycles per FCW value
//   cont_i       1 = continuous sweep, 0 = one-shot
//   fcw_c_o      carrier FCW to the DDFS
//   busy_o       sweep in progress (state == SWEEP)
//   step_o       one-cycle pulse on every fcw_c_o update
//   wrap_o       one-cycle pulse when a continuous sweep reloads start
//   done_o       one-cycle pulse at sweep end
//   cfg_err_o    one-cycle pulse with done_o on a rejected configuration

module ddfs_sweep_ctrl #(
    parameter int PHASE_WIDTH = 32,
    parameter int DWELL_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic                   abort_i,
    input  logic [PHASE_WIDTH-1:0] start_fcw_i,
    input  logic [PHASE_WIDTH-1:0] stop_fcw_i,
    input  logic [PHASE_WIDTH-1:0] step_i,
    input  logic [DWELL_WIDTH-1:0] dwell_i,
    input  logic                   cont_i,
    output logic [PHASE_WIDTH-1:0] fcw_c_o,
    output logic                   busy_o,
    output logic                   step_o,
    output logic                   wrap_o,
    output logic                   done_o,
    output logic                   cfg_err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t state_r, state_s;

    // Shadow configuration, captured on an accepted start.
    logic [PHASE_WIDTH-1:0] start_fcw_r, start_fcw_s;
    logic [PHASE_WIDTH-1:0] stop_fcw_r,  stop_fcw_s;
    logic [PHASE_WIDTH-1:0] inc_r,       inc_s;
    logic [DWELL_WIDTH-1:0] dwell_r,     dwell_s;

    // Datapath and registered outputs.
    logic [PHASE_WIDTH-1:0] fcw_r,       fcw_s;
    logic [DWELL_WIDTH-1:0] cnt_r,       cnt_s;
    logic                   busy_r,      busy_s;
    logic                   step_pls_r,  step_pls_s;
    logic                   done_pls_r,  done_pls_s;
    logic                   cfg_err_r,   cfg_err_s;

    // One bit wider than the FCW so that a carry out marks the end of range
    // instead of silently wrapping to a small frequency.
    logic [PHASE_WIDTH:0]   sum_s;
    logic                   next_ok_s;
    logic                   cfg_bad_s;

`ifdef DDFS_SWEEP_WRAP_EN
    logic                   cont_r,      cont_s;
    logic                   wrap_pls_r,  wrap_pls_s;
`else
    logic                   unused_cont_s;
    assign unused_cont_s = cont_i;
`endif

    // Candidate next FCW and its range check against the latched stop value.
    assign sum_s     = {1'b0, fcw_r} + {1'b0, inc_r};
    assign next_ok_s = (sum_s[PHASE_WIDTH] == 1'b0) &&
                       (sum_s[PHASE_WIDTH-1:0] <= stop_fcw_r);

    // Configuration check runs on the live inputs at the moment of start.
    assign cfg_bad_s = (step_i == {PHASE_WIDTH{1'b0}}) ||
                       (start_fcw_i > stop_fcw_i);

    // Next-state, datapath and pulse-output decode.
    always_comb begin
        state_s     = state_r;
        start_fcw_s = start_fcw_r;
        stop_fcw_s  = stop_fcw_r;
        inc_s       = inc_r;
        dwell_s     = dwell_r;
        fcw_s       = fcw_r;
        cnt_s       = cnt_r;
        step_pls_s  = 1'b0;
        done_pls_s  = 1'b0;
        cfg_err_s   = 1'b0;
`ifdef DDFS_SWEEP_WRAP_EN
        cont_s      = cont_r;
        wrap_pls_s  = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (start_i && !abort_i) begin
                    start_fcw_s = start_fcw_i;
                    stop_fcw_s  = stop_fcw_i;
                    inc_s       = step_i;
                    dwell_s     = dwell_i;
`ifdef DDFS_SWEEP_WRAP_EN
                    cont_s      = cont_i;
`endif
                    if (cfg_bad_s) begin
                        state_s    = DONE;
                        done_pls_s = 1'b1;
                        cfg_err_s  = 1'b1;
                    end else begin
                        state_s    = SWEEP;
                        fcw_s      = start_fcw_i;
                        cnt_s      = dwell_i;
                        step_pls_s = 1'b1;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            SWEEP: begin
                if (abort_i) begin
                    state_s = IDLE;
                end else if (cnt_r != {DWELL_WIDTH{1'b0}}) begin
                    cnt_s = cnt_r - {{(DWELL_WIDTH-1){1'b0}}, 1'b1};
                end else if (next_ok_s) begin
                    fcw_s      = sum_s[PHASE_WIDTH-1:0];
                    cnt_s      = dwell_r;
                    step_pls_s = 1'b1;
                end else begin
`ifdef DDFS_SWEEP_WRAP_EN
                    if (cont_r) begin
                        fcw_s      = start_fcw_r;
                        cnt_s      = dwell_r;
                        step_pls_s = 1'b1;
                        wrap_pls_s = 1'b1;
                    end else begin
                        state_s    = DONE;
                        done_pls_s = 1'b1;
                    end
`else
                    state_s    = DONE;
                    done_pls_s = 1'b1;
`endif
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s == SWEEP);
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Shadow configuration, FCW, dwell counter and registered pulse outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_fcw_r <= {PHASE_WIDTH{1'b0}};
            stop_fcw_r  <= {PHASE_WIDTH{1'b0}};
            inc_r       <= {PHASE_WIDTH{1'b0}};
            dwell_r     <= {DWELL_WIDTH{1'b0}};
            fcw_r       <= {PHASE_WIDTH{1'b0}};
            cnt_r       <= {DWELL_WIDTH{1'b0}};
            busy_r      <= 1'b0;
            step_pls_r  <= 1'b0;
            done_pls_r  <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            start_fcw_r <= start_fcw_s;
            stop_fcw_r  <= stop_fcw_s;
            inc_r       <= inc_s;
            dwell_r     <= dwell_s;
            fcw_r       <= fcw_s;
            cnt_r       <= cnt_s;
            busy_r      <= busy_s;
            step_pls_r  <= step_pls_s;
            done_pls_r  <= done_pls_s;
            cfg_err_r   <= cfg_err_s;
        end
    end

`ifdef DDFS_SWEEP_WRAP_EN
    // Continuous-mode flag and wrap pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cont_r     <= 1'b0;
            wrap_pls_r <= 1'b0;
        end else begin
            cont_r     <= cont_s;
            wrap_pls_r <= wrap_pls_s;
        end
    end

    assign wrap_o = wrap_pls_r;
`else
    assign wrap_o = 1'b0;
`endif

    assign fcw_c_o   = fcw_r;
    assign busy_o    = busy_r;
    assign step_o    = step_pls_r;
    assign done_o    = done_pls_r;
    assign cfg_err_o = cfg_err_r;

endmodule

// File: doc/ddfs_sweep_ctrl.md
DDFS_SWEEP_CTRL -- requirements
Module: ddfs_sweep_ctrl

Interface
REQ-001 SHALL have parameter PHASE_WIDTH, default 32, the width of every frequency control word (FCW).
REQ-002 SHALL have parameter DWELL_WIDTH, default 24, the width of the dwell counter.
REQ-003 SHALL have ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start_i  in  1  one-cycle request to begin a sweep.
- abort_i  in  1  terminates a sweep.
- start_fcw_i  in  PHASE_WIDTH  first FCW of the sweep.
- stop_fcw_i  in  PHASE_WIDTH  last permitted FCW (inclusive).
- step_i  in  PHASE_WIDTH  FCW increment per step.
- dwell_i  in  DWELL_WIDTH  extra hold cycles per FCW.
- cont_i  in  1  1 = continuous (wrapping) sweep, 0 = one-shot.
- fcw_c_o  out  PHASE_WIDTH  carrier FCW to the DDFS fcw_c_i.
- busy_o  out  1  sweep in progress.
- step_o  out  1  one-cycle pulse on every fcw_c_o update.
- wrap_o  out  1  one-cycle pulse when a continuous sweep reloads start.
- done_o  out  1  one-cycle pulse at sweep end.
- cfg_err_o  out  1  one-cycle pulse with done_o on rejected configuration.

Function
REQ-004 SHALL implement FSM states IDLE, SWEEP and DONE.
REQ-005 In IDLE, on start_i=1 with abort_i=0, SHALL latch start_fcw_i, stop_fcw_i, step_i, dwell_i and cont_i into shadow registers; later input changes SHALL have no effect until the next start.
REQ-006 SHALL reject the configuration when step_i==0 or start_fcw_i>stop_fcw_i: next state DONE, cfg_err_o=1 during DONE, fcw_c_o unchanged.
REQ-007 On valid start: next cycle fcw_c_o=start_fcw, dwell count=dwell, step_o=1, busy_o=1, state=SWEEP.
REQ-008 In SWEEP, each FCW value SHALL be held exactly dwell+1 cycles; the dwell counter decrements each cycle and the FCW advances on the edge where the count is 0.
REQ-009 Next FCW SHALL be computed as fcw_c_o+step in PHASE_WIDTH+1 bits; it is valid when no carry occurs and the result is <= stop_fcw.
REQ-010 If valid: fcw_c_o<=next, counter reloads dwell, step_o pulses.
REQ-011 If not valid and continuous: fcw_c_o<=start_fcw, counter reloads, step_o and wrap_o pulse together, state remains SWEEP.
REQ-012 If not valid and one-shot: fcw_c_o holds its last value, state goes to DONE.
REQ-013 DONE SHALL last exactly one cycle, with done_o=1 and busy_o=0, then return to IDLE.
REQ-014 abort_i=1 in SWEEP SHALL force IDLE on the next edge: busy_o=0, fcw_c_o holds, no done_o pulse.
REQ-015 abort_i has priority over start_i and over any step in the same cycle.
REQ-016 start_i in SWEEP or DONE SHALL be ignored.
REQ-017 busy_o SHALL equal (state==SWEEP), and SHALL be registered.
REQ-018 step_o, wrap_o, done_o and cfg_err_o SHALL all be registered outputs.
REQ-019 fcw_c_o SHALL change only on cycles where step_o=1.

Reset
REQ-020 reset=0 SHALL immediately set state=IDLE, fcw_c_o=0, dwell counter=0, shadow registers=0, and all pulse outputs and busy_o to 0.
REQ-021 Reset asserted mid-sweep SHALL discard the sweep; after release the block waits in IDLE for start_i.

Configuration
REQ-022 When DDFS_SWEEP_WRAP_EN is defined, continuous mode SHALL operate per REQ-011.
REQ-023 When DDFS_SWEEP_WRAP_EN is undefined, cont_i SHALL be ignored (treated as 0), wrap_o SHALL be tied 0, and no continuous-mode logic SHALL be synthesized.

Verification
REQ-024 One-shot sweep, start=100, stop=130, step=10, dwell=2 -> fcw_c_o = 100,110,120,130, each held 3 cycles; 4 step_o pulses; done_o 3 cycles after the last step; busy_o low afterwards.
REQ-025 Continuous sweep, start=0, stop=20, step=10, dwell=0 -> fcw_c_o = 0,10,20,0,10,...; wrap_o pulses with every return to 0; done_o never pulses; with DDFS_SWEEP_WRAP_EN undefined the run ends after 20.
REQ-026 Overflow case, PHASE_WIDTH=32, start=0xFFFFFFF0, stop=0xFFFFFFFF, step=0x20, one-shot -> a single value 0xFFFFFFF0, then done_o; no wrap to a small FCW.
REQ-027 Rejected configuration, step=0 (and separately start=50, stop=40) -> done_o and cfg_err_o pulse together one cycle later; fcw_c_o unchanged; busy_o never high.
REQ-028 abort_i raised in the same cycle as a step edge, then start_i and abort_i raised together in IDLE -> FCW does not advance, busy_o drops next cycle, no done_o pulse, and the simultaneous start is ignored.
REQ-029 reset pulled low mid-dwell asynchronously (between clock edges) -> all outputs reach 0 before the next edge; after release, the block stays idle until start_i.
